// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Front-end control stage for the digital stopwatch. Three raw pushbuttons
// are synchronised, debounced and turned into single-cycle press events,
// which drive the IDLE / RUN / PAUSE state machine. The registered outputs
// feed the counter/display block that sits directly downstream.
//
// Parameters
//   DEB_CYCLES : consecutive synchronised samples that must disagree with the
//                accepted level before that level changes (>= 2)
//   DEB_W      : debounce counter width, 2**DEB_W > DEB_CYCLES
//
// Ports
//   clk     in   system clock, all logic on the rising edge
//   rst     in   synchronous reset, active-low (0 = reset)
//   btn_ss  in   raw start/stop button, asynchronous, active-high
//   btn_dir in   raw direction-toggle button, asynchronous, active-high
//   btn_clr in   raw clear button, asynchronous, active-high
//   enable  out  counter run enable, high exactly while state is RUN
//   upDown  out  count direction, 1 = up, 0 = down
//   clr     out  one-cycle clear pulse to the counter
//   state   out  FSM state for status LEDs: 00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_dir,
    input  logic       btn_clr,
    output logic       enable,
    output logic       upDown,
    output logic       clr,
    output logic [1:0] state
);

    // Button lanes inside the packed vectors below.
    localparam int NB      = 3;
    localparam int IDX_SS  = 0;
    localparam int IDX_DIR = 1;
    localparam int IDX_CLR = 2;

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // Button conditioning state
    // -------------------------------------------------------------------------
    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    sync1_q, sync1_d;
    logic [NB-1:0]    sync2_q, sync2_d;
    logic [NB-1:0]    stable_q, stable_d;
    logic [NB-1:0]    stable_dly_q, stable_dly_d;
    logic [DEB_W-1:0] cnt_q [NB];
    logic [DEB_W-1:0] cnt_d [NB];
    logic [NB-1:0]    press;

    logic press_ss;
    logic press_dir;
    logic press_clr;

    // -------------------------------------------------------------------------
    // FSM and output state
    // -------------------------------------------------------------------------
    state_t state_q, state_d;
    logic   enable_q, enable_d;
    logic   updown_q, updown_d;
    logic   clr_q, clr_d;

    assign btn_raw = {btn_clr, btn_dir, btn_ss};

    // -------------------------------------------------------------------------
    // Synchroniser and debouncer, one lane per button.
    // The counter only advances while the synchronised input disagrees with
    // the accepted level; any agreeing sample restarts it, so a glitch shorter
    // than DEB_CYCLES samples can never flip the accepted level.
    // -------------------------------------------------------------------------
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is the first cycle the accepted level is high; holding or
    // releasing the button produces no further event.
    assign press     = stable_q & ~stable_dly_q;
    assign press_ss  = press[IDX_SS];
    assign press_dir = press[IDX_DIR];
    assign press_clr = press[IDX_CLR];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Run/pause FSM: next state and registered outputs.
    // Priority is clear, then start/stop, then direction. Direction is only
    // honoured when it is the sole event of the cycle and the counter is
    // stopped; it is dropped, not remembered, in RUN.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        updown_d = updown_q;
        clr_d    = 1'b0;

        if (press_clr) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_ss) begin
                        state_d = ST_RUN;
                    end else if (press_dir) begin
                        updown_d = ~updown_q;
                    end
                end
                ST_RUN: begin
                    if (press_ss) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (press_ss) begin
                        state_d = ST_RUN;
                    end else if (press_dir) begin
                        updown_d = ~updown_q;
                    end
                end
                default: begin
                    // Unreachable code 11: recover to IDLE with the counter stopped.
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered from the next state so enable and state always agree.
        enable_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            updown_q <= 1'b1;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            updown_q <= updown_d;
            clr_q    <= clr_d;
        end
    end

    assign enable = enable_q;
    assign upDown = updown_q;
    assign clr    = clr_q;
    assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_ss;
    logic       btn_dir;
    logic       btn_clr;
    logic       enable;
    logic       upDown;
    logic       clr;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(
        .DEB_CYCLES(4),
        .DEB_W     (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_ss (btn_ss),
        .btn_dir(btn_dir),
        .btn_clr(btn_clr),
        .enable (enable),
        .upDown (upDown),
        .clr    (clr),
        .state  (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       ss;
        logic       dir;
        logic       cbtn;
        int         hold;
        logic       exp_en;
        logic       exp_ud;
        logic       exp_clr;
        logic [1:0] exp_st;
        int         exp_pulses;
        int         exp_trans;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   lat_sb[$];

    function automatic void add(logic r, logic s, logic d, logic c, int h,
                                logic en, logic ud, logic cl, logic [1:0] st,
                                int pulses, int trans, string nm);
        vec_t v;
        v.rst = r; v.ss = s; v.dir = d; v.cbtn = c; v.hold = h;
        v.exp_en = en; v.exp_ud = ud; v.exp_clr = cl; v.exp_st = st;
        v.exp_pulses = pulses; v.exp_trans = trans; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic c);
        rst     = r;
        btn_ss  = s;
        btn_dir = d;
        btn_clr = c;
    endtask

    initial begin
        vec_t       v;
        vec_t       e;
        int         pulses;
        int         trans;
        int         n;
        int         lat_exp;
        logic [1:0] prev;

        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //    rst ss dir clr hold  en ud clr st     pulses trans name
        add(0, 0, 0, 0,  3,  0, 1, 0, 2'b00, 0, -1, "reset");
        add(1, 0, 0, 0,  5,  0, 1, 0, 2'b00, 0,  0, "idle_quiet");
        add(1, 1, 0, 0,  3,  0, 1, 0, 2'b00, 0,  0, "bounce_hi3");
        add(1, 0, 0, 0,  2,  0, 1, 0, 2'b00, 0,  0, "bounce_lo2");
        add(1, 1, 0, 0,  2,  0, 1, 0, 2'b00, 0,  0, "bounce_hi2");
        add(1, 1, 0, 0, 20,  1, 1, 0, 2'b01, 0,  1, "ss_held_run");
        add(1, 0, 0, 0, 10,  1, 1, 0, 2'b01, 0,  0, "ss_release");
        add(1, 1, 0, 0, 10,  0, 1, 0, 2'b10, 0,  1, "ss_pause");
        add(1, 0, 0, 0, 10,  0, 1, 0, 2'b10, 0,  0, "ss_pause_rel");
        add(1, 1, 0, 0, 10,  1, 1, 0, 2'b01, 0,  1, "ss_resume");
        add(1, 0, 0, 0, 10,  1, 1, 0, 2'b01, 0,  0, "ss_resume_rel");
        add(1, 0, 1, 0, 10,  1, 1, 0, 2'b01, 0,  0, "dir_in_run");
        add(1, 0, 0, 0, 10,  1, 1, 0, 2'b01, 0,  0, "dir_in_run_rel");
        add(1, 1, 0, 0, 10,  0, 1, 0, 2'b10, 0,  1, "ss_pause2");
        add(1, 0, 0, 0, 10,  0, 1, 0, 2'b10, 0,  0, "ss_pause2_rel");
        add(1, 0, 1, 0, 10,  0, 0, 0, 2'b10, 0,  0, "dir_pause_a");
        add(1, 0, 0, 0, 10,  0, 0, 0, 2'b10, 0,  0, "dir_pause_a_rel");
        add(1, 0, 1, 0, 10,  0, 1, 0, 2'b10, 0,  0, "dir_pause_b");
        add(1, 0, 0, 0, 10,  0, 1, 0, 2'b10, 0,  0, "dir_pause_b_rel");
        add(1, 0, 1, 0, 10,  0, 0, 0, 2'b10, 0,  0, "dir_pause_c");
        add(1, 0, 0, 0, 10,  0, 0, 0, 2'b10, 0,  0, "dir_pause_c_rel");
        add(1, 1, 0, 0, 10,  1, 0, 0, 2'b01, 0,  1, "ss_run_down");
        add(1, 0, 0, 0, 10,  1, 0, 0, 2'b01, 0,  0, "ss_run_down_rel");
        add(1, 1, 0, 1, 10,  0, 0, 0, 2'b00, 1,  1, "clr_prio");
        add(1, 0, 0, 0, 10,  0, 0, 0, 2'b00, 0,  0, "clr_prio_rel");
        add(1, 1, 1, 0, 10,  1, 0, 0, 2'b01, 0,  1, "ss_dir_same");
        add(1, 0, 0, 0, 10,  1, 0, 0, 2'b01, 0,  0, "ss_dir_same_rel");
        add(0, 1, 0, 0,  1,  0, 1, 0, 2'b00, 0,  1, "reset_in_run");

        for (int p = 0; p < vecs.size(); p++) begin
            v = vecs[p];
            @(negedge clk);
            drive(v.rst, v.ss, v.dir, v.cbtn);
            sb.push_back(v);
            pulses = 0;
            trans  = 0;
            prev   = state;
            repeat (v.hold) begin
                @(posedge clk);
                #1;
                if (clr === 1'b1) pulses++;
                if (state !== prev) trans++;
                prev = state;
            end
            e = sb.pop_front();
            check({e.name, ".state"},  state,  e.exp_st);
            check({e.name, ".enable"}, enable, e.exp_en);
            check({e.name, ".upDown"}, upDown, e.exp_ud);
            check({e.name, ".clr"},    clr,    e.exp_clr);
            check({e.name, ".clr_pulses"}, pulses, e.exp_pulses);
            if (e.exp_trans >= 0) check({e.name, ".transitions"}, trans, e.exp_trans);
        end

        // Button held through reset release: RUN exactly 7 edges later.
        @(negedge clk);
        rst = 1'b1;
        lat_sb.push_back(7);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (state === 2'b01) break;
        end
        if (n >= 30) begin
            checks++;
            failures++;
            $display("FAIL rst_release_latency actual=timeout required=7");
        end
        lat_exp = lat_sb.pop_front();
        check("rst_release_latency", n, lat_exp);
        check("rst_release_enable", enable, 1'b1);

        @(negedge clk);
        btn_ss = 1'b0;
        repeat (10) @(posedge clk);

        // Lone clear press: latency, single-cycle width, return to IDLE.
        @(negedge clk);
        btn_clr = 1'b1;
        lat_sb.push_back(7);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (clr === 1'b1) break;
        end
        if (n >= 30) begin
            checks++;
            failures++;
            $display("FAIL clr_latency actual=timeout required=7");
        end
        lat_exp = lat_sb.pop_front();
        check("clr_latency", n, lat_exp);
        check("clr_state_idle", state, 2'b00);
        check("clr_enable_low", enable, 1'b0);
        @(posedge clk);
        #1;
        check("clr_width_one", clr, 1'b0);
        check("clr_upDown_kept", upDown, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
